program_feeder: RTL and testbench
=================================

// Module: program_feeder
// PURPOSE
//  Drives the processor's switch-side interface from a stored program.
//  The program is loaded into internal memory, then replayed: the block presents each
//  10-bit word on the processor data input and issues step pulses in place of KEY0.
//  It watches the processor's DONE (Clr) to tell where each instruction ends.
// PARAMETERS
//  DATA_W     10  width of instruction/immediate words
//  DEPTH      16  program memory entries; address width AW = $clog2(DEPTH)
//  SETUP_W    4   cycles OUT_DATA is stable before each STEP_b fall
//  PULSE_W    4   cycles STEP_b is held low per step
//  GAP_W      4   cycles STEP_b is held high after each pulse, before DONE is sampled
//  MAX_STEPS  4   maximum pulses per instruction (2-bit processor time counter)
// PORTS
//  CLK        in   1       single system clock
//  RST        in   1       asynchronous, active-high reset
//  LOAD_WE    in   1       program memory write strobe; ignored while BUSY
//  LOAD_ADDR  in   AW      write address
//  LOAD_DATA  in   DATA_W+1  {IMM tag, word}; IMM=1: next entry is this instr's immediate
//  PROG_LEN   in   AW+1    number of entries to replay; sampled at START
//  START      in   1       1-cycle pulse; begins replay from entry 0; ignored while BUSY
//  DONE       in   1       processor DONE/Clr; high during final time step of an instr
//  OUT_DATA   out  DATA_W  drives processor IN_DATA_BUS
//  STEP_b     out  1       active-low step pulse to processor clock input; idle high
//  PC         out  AW      entry currently presented
//  BUSY       out  1       high from START accept until FINISH/ERROR
//  FINISHED   out  1       sticky; program completed
//  ERR        out  1       sticky; step overrun or dangling IMM tag
// BEHAVIOUR
//  Reset (async): OUT_DATA=0, STEP_b=1, PC=0, BUSY=0, FINISHED=0, ERR=0, FSM=IDLE.
//   Memory contents are not cleared. Reset mid-replay: STEP_b goes high immediately, with no partial pulse.
//  Memory: synchronous write on LOAD_WE & !BUSY. Read is combinational on PC.
//  States: IDLE, FETCH, SETUP, PULSE, GAP, CHECK, NEXT, FINISH, ERROR.
//  IDLE: on START, clear FINISHED/ERR, latch PROG_LEN, PC=0, BUSY=1.
//   If PROG_LEN==0 -> FINISH, else -> FETCH.
//  FETCH: OUT_DATA<=mem[PC].word; step_cnt=0, last=0, imm_done=0 -> SETUP.
//  SETUP: SETUP_W cycles, STEP_b=1 -> PULSE.
//  PULSE: STEP_b=0 for PULSE_W cycles; step_cnt++ on entry -> GAP.
//  GAP: STEP_b=1 for GAP_W cycles; DONE is registered on the last GAP cycle -> CHECK.
//  CHECK (one cycle), first matching rule applies:
//   1. last==1 -> NEXT.
//   2. mem[PC].IMM & !imm_done & step_cnt==1:
//      if PC+1>=len -> ERROR; else PC++, OUT_DATA<=mem[PC+1].word, imm_done=1 -> SETUP.
//   3. DONE sampled high -> last=1 -> SETUP (one final pulse).
//   4. step_cnt==MAX_STEPS -> ERROR.
//   5. otherwise -> SETUP.
//  NEXT: PC++; if PC+1==len -> FINISH, else -> FETCH.
//  FINISH: BUSY=0, FINISHED=1, STEP_b=1, OUT_DATA holds -> IDLE.
//  ERROR: BUSY=0, ERR=1, STEP_b=1, PC holds faulting entry -> IDLE.
//  OUT_DATA changes only in FETCH/CHECK. It is stable from SETUP through GAP.
//  A START pulse that coincides with LOAD_WE: both are accepted, and the write lands before the first FETCH read.
// TESTING
//  1. Reset mid-PULSE -> STEP_b=1 within 0 cycles. BUSY=0, PC=0. Memory retains the loaded words.
//  2. Load {0,0x0A5}, len=1. Model asserts DONE after pulse 2.
//     -> 3 pulses with OUT_DATA=0x0A5, then FINISHED=1, PC=0.
//  3. Load {1,0x040},{0,0x3FF}, len=2. DONE after pulse 3.
//     -> pulse 1 shows 0x040; pulses 2-4 show 0x3FF; then FINISHED=1.
//  4. Load {1,0x040}, len=1 -> ERROR after pulse 1. ERR=1, PC=0.
//  5. DONE tied low, len=1 -> exactly 4 pulses, then ERR=1.
//  6. START and LOAD_WE issued while BUSY -> both ignored. The memory word and the replay order are unchanged.
//  7. len=0 -> FINISHED=1 with zero pulses.

Source files
------------

// File: rtl/program_feeder_if.sv
// Switch-side bus between the program feeder and the processor/loader.
// The slave modport is the feeder's view; master is the processor/loader side.
interface program_feeder_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [DATA_W:0]   load_data;
    logic [AW:0]       prog_len;
    logic              start;
    logic              done;
    logic [DATA_W-1:0] out_data;
    logic              step_b;
    logic [AW-1:0]     pc;
    logic              busy;
    logic              finished;
    logic              err;

    modport slave (
        input  load_we, load_addr, load_data, prog_len, start, done,
        output out_data, step_b, pc, busy, finished, err
    );

    modport master (
        output load_we, load_addr, load_data, prog_len, start, done,
        input  out_data, step_b, pc, busy, finished, err
    );
endinterface

// File: rtl/program_feeder.sv
// Replays a stored program into the processor's switch inputs, issuing active-low
// step pulses and using the processor's DONE to find instruction boundaries.
module program_feeder #(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned SETUP_W   = 4,
    parameter int unsigned PULSE_W   = 4,
    parameter int unsigned GAP_W     = 4,
    parameter int unsigned MAX_STEPS = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    program_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 8;
    localparam int unsigned SW = $clog2(MAX_STEPS + 2);

    typedef enum logic [3:0] {
        StIdle, StFetch, StSetup, StPulse, StGap, StCheck, StNext, StFinish, StError
    } state_e;

    state_e            r_state;
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [DATA_W-1:0] r_out_data;
    logic              r_step_b;
    logic [AW-1:0]     r_pc;
    logic [AW:0]       r_len;
    logic              r_busy;
    logic              r_finished;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_step_cnt;
    logic              r_last;
    logic              r_imm_done;
    logic              r_done_q;

    logic [DATA_W:0]   w_cur;
    logic [AW:0]       w_pc_inc_ext;
    logic [AW-1:0]     w_pc_inc;
    logic [DATA_W-1:0] w_nxt_word;

    assign w_cur        = r_mem[r_pc];
    assign w_pc_inc_ext = {1'b0, r_pc} + 1'b1;
    assign w_pc_inc     = w_pc_inc_ext[AW-1:0];
    assign w_nxt_word   = r_mem[w_pc_inc][DATA_W-1:0];

    // Program memory survives reset; writes are locked out during replay.
    always_ff @(posedge i_clk) begin
        if (bus.load_we && !r_busy) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_out_data <= '0;
            r_step_b   <= 1'b1;
            r_pc       <= '0;
            r_len      <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_step_cnt <= '0;
            r_last     <= 1'b0;
            r_imm_done <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_finished <= 1'b0;
                        r_err      <= 1'b0;
                        r_len      <= bus.prog_len;
                        r_pc       <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= (bus.prog_len == '0) ? StFinish : StFetch;
                    end
                end
                StFetch: begin
                    r_out_data <= w_cur[DATA_W-1:0];
                    r_step_cnt <= '0;
                    r_last     <= 1'b0;
                    r_imm_done <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= StSetup;
                end
                StSetup: begin
                    if (r_cnt == CW'(SETUP_W - 1)) begin
                        r_cnt      <= '0;
                        r_step_b   <= 1'b0;
                        r_step_cnt <= r_step_cnt + 1'b1;
                        r_state    <= StPulse;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StPulse: begin
                    if (r_cnt == CW'(PULSE_W - 1)) begin
                        r_cnt    <= '0;
                        r_step_b <= 1'b1;
                        r_state  <= StGap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (r_cnt == CW'(GAP_W - 1)) begin
                        r_cnt    <= '0;
                        r_done_q <= bus.done;
                        r_state  <= StCheck;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StCheck: begin
                    // Immediate fetch takes priority over DONE on the first pulse.
                    if (r_last) begin
                        r_state <= StNext;
                    end else if (w_cur[DATA_W] && !r_imm_done && r_step_cnt == SW'(1)) begin
                        if (w_pc_inc_ext >= r_len) begin
                            r_state <= StError;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_out_data <= w_nxt_word;
                            r_imm_done <= 1'b1;
                            r_state    <= StSetup;
                        end
                    end else if (r_done_q) begin
                        r_last  <= 1'b1;
                        r_state <= StSetup;
                    end else if (r_step_cnt == SW'(MAX_STEPS)) begin
                        r_state <= StError;
                    end else begin
                        r_state <= StSetup;
                    end
                end
                StNext: begin
                    if (w_pc_inc_ext == r_len) begin
                        r_state <= StFinish;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= StFetch;
                    end
                end
                StFinish: begin
                    r_busy     <= 1'b0;
                    r_finished <= 1'b1;
                    r_step_b   <= 1'b1;
                    r_state    <= StIdle;
                end
                StError: begin
                    r_busy   <= 1'b0;
                    r_err    <= 1'b1;
                    r_step_b <= 1'b1;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.out_data = r_out_data;
    assign bus.step_b   = r_step_b;
    assign bus.pc       = r_pc;
    assign bus.busy     = r_busy;
    assign bus.finished = r_finished;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_program_feeder.sv
// Randomized bench for program_feeder: a small processor model answers DONE, and a
// pulse-level reference model predicts pulse data and the final status.
module tb_program_feeder;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fb ();

    program_feeder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (fb)
    );

    logic [10:0] m_mem [16];
    int          d_list [32];
    logic [9:0]  obs_q [$];
    logic [9:0]  exp_q [$];
    int          p_t;
    int          p_idx;
    int          n_pass;
    int          n_checks;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Processor: DONE is high once its time counter reaches the instruction's length.
    assign fb.done = (p_t == d_list[p_idx]);

    always @(negedge fb.step_b) begin
        if (!rst) begin
            obs_q.push_back(fb.out_data);
            if (p_t == d_list[p_idx]) begin
                p_t = 0;
                if (p_idx < 31) p_idx++;
            end else begin
                p_t++;
            end
        end
    end

    always @(posedge fb.step_b) begin
        if (!rst && obs_q.size() > 0) check_eq("stable", 32'(fb.out_data), 32'(obs_q[$]));
    end

    task automatic model_run(input int len, output logic fin, output logic er, output int pc_o);
        int pc;
        int instr;
        int steps;
        bit imm_done;
        bit last;
        logic [9:0] data;
        exp_q.delete();
        fin = 1'b0;
        er = 1'b0;
        pc = 0;
        pc_o = 0;
        instr = 0;
        if (len == 0) begin
            fin = 1'b1;
            return;
        end
        forever begin
            data = m_mem[pc][9:0];
            steps = 0;
            imm_done = 1'b0;
            last = 1'b0;
            forever begin
                steps++;
                exp_q.push_back(data);
                if (last) break;
                if (m_mem[pc][10] && !imm_done && steps == 1) begin
                    if (pc + 1 >= len) begin
                        er = 1'b1;
                        pc_o = pc;
                        return;
                    end
                    pc++;
                    data = m_mem[pc][9:0];
                    imm_done = 1'b1;
                end else if (steps == d_list[instr]) begin
                    last = 1'b1;
                end else if (steps == 4) begin
                    er = 1'b1;
                    pc_o = pc;
                    return;
                end
            end
            if (pc + 1 == len) begin
                fin = 1'b1;
                pc_o = pc;
                return;
            end
            pc++;
            instr++;
        end
    endtask

    task automatic load(input int addr, input logic [10:0] word);
        @(negedge clk);
        fb.load_we   = 1'b1;
        fb.load_addr = 4'(addr);
        fb.load_data = word;
        m_mem[addr]  = word;
        @(negedge clk);
        fb.load_we   = 1'b0;
    endtask

    // poke: issue START and a write to entry 0 mid-replay; co_load: write entry 0 with START.
    task automatic run(input string tag, input int len, input bit poke, input bit co_load,
                       input logic [10:0] co_word);
        logic efin;
        logic eerr;
        int   epc;
        int   guard;
        if (co_load) m_mem[0] = co_word;
        model_run(len, efin, eerr, epc);
        obs_q.delete();
        p_t = 0;
        p_idx = 0;
        @(negedge clk);
        fb.prog_len = 5'(len);
        fb.start = 1'b1;
        if (co_load) begin
            fb.load_we   = 1'b1;
            fb.load_addr = '0;
            fb.load_data = co_word;
        end
        @(negedge clk);
        fb.start = 1'b0;
        fb.load_we = 1'b0;
        check_eq({tag, "/busy"}, 32'(fb.busy), 32'd1);
        guard = 0;
        while (fb.busy && guard < 3000) begin
            if (poke && guard == 20) begin
                fb.start     = 1'b1;
                fb.prog_len  = 5'd1;
                fb.load_we   = 1'b1;
                fb.load_addr = '0;
                fb.load_data = 11'h2EE;
            end
            @(negedge clk);
            fb.start   = 1'b0;
            fb.load_we = 1'b0;
            guard++;
        end
        check_eq({tag, "/no_timeout"}, 32'(guard < 3000), 32'd1);
        check_eq({tag, "/npulse"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s/pulse%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        check_eq({tag, "/finished"}, 32'(fb.finished), 32'(efin));
        check_eq({tag, "/err"}, 32'(fb.err), 32'(eerr));
        check_eq({tag, "/pc"}, 32'(fb.pc), 32'(epc));
    endtask

    initial begin
        int g;
        int len;
        n_pass = 0;
        n_checks = 0;
        p_t = 0;
        p_idx = 0;
        fb.load_we = 1'b0;
        fb.load_addr = '0;
        fb.load_data = '0;
        fb.prog_len = '0;
        fb.start = 1'b0;
        for (int i = 0; i < 32; i++) d_list[i] = 7;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst/step_b", 32'(fb.step_b), 32'd1);
        check_eq("rst/busy", 32'(fb.busy), 32'd0);
        check_eq("rst/out", 32'(fb.out_data), 32'd0);
        check_eq("rst/flags", 32'({fb.finished, fb.err}), 32'd0);
        rst = 1'b0;

        // Fill memory so every entry has a known value.
        for (int i = 0; i < 16; i++) load(i, 11'(i + 1));

        run("len0", 0, 1'b0, 1'b0, '0);
        check_eq("len0/zero", 32'(obs_q.size()), 32'd0);

        load(0, {1'b0, 10'h0A5});
        d_list[0] = 2;
        run("simple", 1, 1'b0, 1'b0, '0);
        check_eq("simple/three", 32'(obs_q.size()), 32'd3);

        load(0, {1'b1, 10'h040});
        load(1, {1'b0, 10'h3FF});
        d_list[0] = 3;
        run("imm", 2, 1'b0, 1'b0, '0);
        check_eq("imm/four", 32'(obs_q.size()), 32'd4);

        run("dangling", 1, 1'b0, 1'b0, '0);
        check_eq("dangling/one", 32'(obs_q.size()), 32'd1);

        load(0, {1'b0, 10'h2AA});
        d_list[0] = 7;
        run("overrun", 1, 1'b0, 1'b0, '0);
        check_eq("overrun/four", 32'(obs_q.size()), 32'd4);

        // Reset in the middle of a low pulse.
        load(0, {1'b0, 10'h155});
        @(negedge clk);
        fb.prog_len = 5'd1;
        fb.start = 1'b1;
        @(negedge clk);
        fb.start = 1'b0;
        g = 0;
        while (fb.step_b && g < 200) begin
            @(negedge clk);
            g++;
        end
        check_eq("midrst/saw_pulse", 32'(g < 200), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst/step_b", 32'(fb.step_b), 32'd1);
        check_eq("midrst/busy", 32'(fb.busy), 32'd0);
        check_eq("midrst/pc", 32'(fb.pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d_list[0] = 2;
        run("retained", 1, 1'b0, 1'b0, '0);

        // Writes and START while busy must be ignored.
        load(0, {1'b0, 10'h111});
        load(1, {1'b0, 10'h222});
        load(2, {1'b0, 10'h333});
        d_list[0] = 1;
        d_list[1] = 2;
        d_list[2] = 3;
        run("busy_poke", 3, 1'b1, 1'b0, '0);
        run("busy_after", 3, 1'b0, 1'b0, '0);

        d_list[0] = 1;
        run("co_load", 1, 1'b0, 1'b1, {1'b0, 10'h1C3});

        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                load(i, {1'($urandom_range(0, 3) == 0), 10'($urandom)});
            end
            for (int i = 0; i < 32; i++) begin
                d_list[i] = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(2, 4);
            end
            run($sformatf("rand%0d", r), len, 1'b0, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
